control_unit: RTL and testbench



---
 rtl/cu_pkg.sv | 43 ++++
 rtl/control_unit_if.sv | 28 ++
 rtl/cu_decode.sv | 60 ++++++
 rtl/control_unit.sv | 136 +++++++++++++
 tb/tb_control_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// supported RV64 opcodes, ALU command codes and the registered control word.
// Ports: none (package).
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] CMD_R  = 4'b0000;
  localparam logic [3:0] CMD_I  = 4'b0001;
  localparam logic [3:0] CMD_S  = 4'b0010;
  localparam logic [3:0] CMD_SB = 4'b0011;

  // Position of the ALU zero flag inside alu_flags.
  localparam int FLAG_ZERO = 2;

  // Every control output of the block, held in one register.
  typedef struct packed {
    logic       ir_load;
    logic       pc_load;
    logic       d_mem_we;
    logic       rf_we;
    logic [3:0] alu_cmd;
    logic       alu_src;
    logic       pc_src;
    logic       rf_src;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control interface between the control unit and the datapath.
// Latency: n/a (wires only). Backpressure: none, level signals.
// master = control unit (consumes opcode/alu_flags, drives control strobes);
// slave  = datapath (drives opcode/alu_flags, consumes control strobes).
interface control_unit_if;

  logic [6:0] opcode;
  logic [3:0] alu_flags;
  logic       ir_load;
  logic       pc_load;
  logic       d_mem_we;
  logic       rf_we;
  logic [3:0] alu_cmd;
  logic       alu_src;
  logic       pc_src;
  logic       rf_src;

  modport master (
    input  opcode, alu_flags,
    output ir_load, pc_load, d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src
  );

  modport slave (
    output opcode, alu_flags,
    input  ir_load, pc_load, d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src
  );

endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: classifies an opcode into the fields the FSM needs.
// Latency: combinational. Backpressure: none.
// Ports: opcode_i in; legal_o, alu_cmd_o, alu_src_o, is_mem_o, is_store_o,
//        writes_rf_o, is_branch_o out.
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       legal_o,
  output logic [3:0] alu_cmd_o,
  output logic       alu_src_o,
  output logic       is_mem_o,
  output logic       is_store_o,
  output logic       writes_rf_o,
  output logic       is_branch_o
);

  always_comb begin
    legal_o     = 1'b0;
    alu_cmd_o   = CMD_R;
    alu_src_o   = 1'b0;
    is_mem_o    = 1'b0;
    is_store_o  = 1'b0;
    writes_rf_o = 1'b0;
    is_branch_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        legal_o     = 1'b1;
        writes_rf_o = 1'b1;
      end
      OP_LD: begin
        legal_o     = 1'b1;
        alu_cmd_o   = CMD_I;
        alu_src_o   = 1'b1;
        is_mem_o    = 1'b1;
        writes_rf_o = 1'b1;
      end
      OP_ADDI: begin
        legal_o     = 1'b1;
        alu_cmd_o   = CMD_I;
        alu_src_o   = 1'b1;
        writes_rf_o = 1'b1;
      end
      OP_SD: begin
        legal_o    = 1'b1;
        alu_cmd_o  = CMD_S;
        alu_src_o  = 1'b1;
        is_mem_o   = 1'b1;
        is_store_o = 1'b1;
      end
      OP_BEQ: begin
        legal_o     = 1'b1;
        alu_cmd_o   = CMD_SB;
        is_branch_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback for one
// RV64 instruction at a time, plus a retired-instruction counter.
// Latency: 4 cycles FETCH..retire (R, ADDI, BEQ, SD), 5 for LD. Backpressure:
// none; run is a level enable checked only when an instruction could start.
// Ports: clk, rst (sync, active-high), run in; cu (control_unit_if.master);
//        halted, state (debug), instr_count out.
module control_unit
  import cu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  control_unit_if.master   cu,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic             taken_q, taken_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q;

  logic       dec_legal;
  logic [3:0] dec_alu_cmd;
  logic       dec_alu_src;
  logic       dec_is_mem;
  logic       dec_is_store;
  logic       dec_writes_rf;
  logic       dec_is_branch;

  // MSB and overflow flags carry no meaning for this block.
  logic unused_flags;
  assign unused_flags = ^{cu.alu_flags[3], cu.alu_flags[1:0]};

  // The opcode is captured only in DECODE; elsewhere the held copy is kept.
  assign opcode_d = (state_q == ST_DECODE) ? cu.opcode : opcode_q;

  // Decoding the next-cycle opcode lets the control word be computed for the
  // next state and registered, so outputs are flops driven only by
  // state/opcode_q/taken_q. In DECODE this same result gives legality.
  cu_decode u_decode (
    .opcode_i    (opcode_d),
    .legal_o     (dec_legal),
    .alu_cmd_o   (dec_alu_cmd),
    .alu_src_o   (dec_alu_src),
    .is_mem_o    (dec_is_mem),
    .is_store_o  (dec_is_store),
    .writes_rf_o (dec_writes_rf),
    .is_branch_o (dec_is_branch)
  );

  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE:      state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = dec_legal ? ST_EXECUTE : ST_HALT;
      ST_EXECUTE: begin
        if (dec_is_branch) taken_d = cu.alu_flags[FLAG_ZERO];
        state_d = dec_is_mem ? ST_MEMORY : ST_WRITEBACK;
      end
      // A store retires in MEMORY; a load still needs WRITEBACK.
      ST_MEMORY: begin
        if (dec_is_store) state_d = run ? ST_FETCH : ST_IDLE;
        else              state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Control word for the state being entered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH: ctrl_d.ir_load = 1'b1;
      ST_EXECUTE: begin
        ctrl_d.alu_cmd = dec_alu_cmd;
        ctrl_d.alu_src = dec_alu_src;
      end
      ST_MEMORY: begin
        ctrl_d.alu_cmd  = dec_alu_cmd;
        ctrl_d.alu_src  = dec_alu_src;
        ctrl_d.rf_src   = dec_is_mem & ~dec_is_store;
        ctrl_d.d_mem_we = dec_is_store;
        ctrl_d.pc_load  = dec_is_store;
      end
      ST_WRITEBACK: begin
        ctrl_d.alu_cmd = dec_alu_cmd;
        ctrl_d.alu_src = dec_alu_src;
        ctrl_d.pc_load = 1'b1;
        ctrl_d.rf_we   = dec_writes_rf;
        ctrl_d.rf_src  = dec_is_mem & ~dec_is_store;
        ctrl_d.pc_src  = dec_is_branch & taken_d;
      end
      ST_HALT:  ctrl_d.halted = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      taken_q  <= 1'b0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      taken_q  <= taken_d;
      ctrl_q   <= ctrl_d;
      // Count the retire cycle as it ends; wraps freely.
      if (ctrl_q.pc_load) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cu.ir_load   = ctrl_q.ir_load;
  assign cu.pc_load   = ctrl_q.pc_load;
  assign cu.d_mem_we  = ctrl_q.d_mem_we;
  assign cu.rf_we     = ctrl_q.rf_we;
  assign cu.alu_cmd   = ctrl_q.alu_cmd;
  assign cu.alu_src   = ctrl_q.alu_src;
  assign cu.pc_src    = ctrl_q.pc_src;
  assign cu.rf_src    = ctrl_q.rf_src;
  assign halted       = ctrl_q.halted;
  assign state        = state_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle vector table (inputs, expected state,
// control word, instr_count) applied to a CNT_W=32 and a CNT_W=2 instance
// driven in lockstep, plus a hand sequence for input changes mid-cycle.
module tb_control_unit;

  // Opcodes
  localparam logic [6:0] R    = 7'h33;
  localparam logic [6:0] LD   = 7'h03;
  localparam logic [6:0] ADDI = 7'h13;
  localparam logic [6:0] SD   = 7'h23;
  localparam logic [6:0] BEQ  = 7'h63;
  localparam logic [6:0] ILL  = 7'h7F;

  // Control word {ir_load,pc_load,d_mem_we,rf_we,alu_cmd[3:0],alu_src,pc_src,rf_src,halted}
  localparam logic [11:0] O_NONE  = 12'h000;
  localparam logic [11:0] O_FETCH = 12'h800;
  localparam logic [11:0] O_HALT  = 12'h001;
  localparam logic [11:0] O_R_WB  = 12'h500;
  localparam logic [11:0] O_I_EX  = 12'h018;
  localparam logic [11:0] O_LD_MM = 12'h01A;
  localparam logic [11:0] O_LD_WB = 12'h51A;
  localparam logic [11:0] O_AI_WB = 12'h518;
  localparam logic [11:0] O_SD_EX = 12'h028;
  localparam logic [11:0] O_SD_MM = 12'h628;
  localparam logic [11:0] O_BQ_EX = 12'h030;
  localparam logic [11:0] O_BQ_TK = 12'h434;
  localparam logic [11:0] O_BQ_NT = 12'h430;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [6:0] op  = 7'h00;
  logic [3:0] fl  = 4'h0;

  control_unit_if ifa ();
  control_unit_if ifb ();
  assign ifa.opcode    = op;
  assign ifa.alu_flags = fl;
  assign ifb.opcode    = op;
  assign ifb.alu_flags = fl;

  logic        halted_a, halted_b;
  logic [2:0]  st_a, st_b;
  logic [31:0] cnt_a;
  logic [1:0]  cnt_b;

  control_unit u_dut (
    .clk(clk), .rst(rst), .run(run), .cu(ifa),
    .halted(halted_a), .state(st_a), .instr_count(cnt_a)
  );

  control_unit #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .run(run), .cu(ifb),
    .halted(halted_b), .state(st_b), .instr_count(cnt_b)
  );

  function automatic logic [11:0] outs_a();
    return {ifa.ir_load, ifa.pc_load, ifa.d_mem_we, ifa.rf_we, ifa.alu_cmd,
            ifa.alu_src, ifa.pc_src, ifa.rf_src, halted_a};
  endfunction

  function automatic logic [11:0] outs_b();
    return {ifb.ir_load, ifb.pc_load, ifb.d_mem_we, ifb.rf_we, ifb.alu_cmd,
            ifb.alu_src, ifb.pc_src, ifb.rf_src, halted_b};
  endfunction

  typedef struct {
    logic        rst;
    logic        run;
    logic [6:0]  op;
    logic [3:0]  fl;
    logic [2:0]  st;
    logic [11:0] outs;
    int          cnt;
  } vec_t;

  vec_t vecs[$];
  int applied = 0;
  int miscompares = 0;

  task automatic add(input logic r, input logic rn, input logic [6:0] o,
                     input logic [3:0] f, input logic [2:0] s,
                     input logic [11:0] w, input int c);
    vec_t v;
    v.rst = r; v.run = rn; v.op = o; v.fl = f; v.st = s; v.outs = w; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] s,
                           input logic [11:0] w, input int c);
    check({tag, " state"},   32'(st_a), 32'(s));
    check({tag, " ctrl"},    32'(outs_a()), 32'(w));
    check({tag, " count"},   cnt_a, 32'(c));
    check({tag, " state2"},  32'(st_b), 32'(s));
    check({tag, " ctrl2"},   32'(outs_b()), 32'(w));
    check({tag, " count2"},  32'(cnt_b), 32'(c % 4));
  endtask

  initial begin
    // Reset held two cycles with run high
    add(1, 1, R, 4'h0, 3'd0, O_NONE, 0);
    add(1, 1, R, 4'h0, 3'd0, O_NONE, 0);
    // R-type
    add(0, 1, R, 4'h0, 3'd1, O_FETCH, 0);
    add(0, 1, R, 4'h0, 3'd2, O_NONE,  0);
    add(0, 1, R, 4'h0, 3'd3, O_NONE,  0);
    add(0, 1, R, 4'h0, 3'd5, O_R_WB,  0);
    // LD then SD back-to-back
    add(0, 1, LD, 4'h0, 3'd1, O_FETCH, 1);
    add(0, 1, LD, 4'h0, 3'd2, O_NONE,  1);
    add(0, 1, LD, 4'h0, 3'd3, O_I_EX,  1);
    add(0, 1, LD, 4'h0, 3'd4, O_LD_MM, 1);
    add(0, 1, LD, 4'h0, 3'd5, O_LD_WB, 1);
    add(0, 1, SD, 4'h0, 3'd1, O_FETCH, 2);
    add(0, 1, SD, 4'h0, 3'd2, O_NONE,  2);
    add(0, 1, SD, 4'h0, 3'd3, O_SD_EX, 2);
    add(0, 1, SD, 4'h0, 3'd4, O_SD_MM, 2);
    // BEQ taken: zero flag present while in EXECUTE
    add(0, 1, BEQ, 4'h0, 3'd1, O_FETCH, 3);
    add(0, 1, BEQ, 4'h0, 3'd2, O_NONE,  3);
    add(0, 1, BEQ, 4'h0, 3'd3, O_BQ_EX, 3);
    add(0, 1, BEQ, 4'h4, 3'd5, O_BQ_TK, 3);
    // BEQ not taken: zero flag high outside EXECUTE only
    add(0, 1, BEQ, 4'h4, 3'd1, O_FETCH, 4);
    add(0, 1, BEQ, 4'h4, 3'd2, O_NONE,  4);
    add(0, 1, BEQ, 4'h4, 3'd3, O_BQ_EX, 4);
    add(0, 1, BEQ, 4'h0, 3'd5, O_BQ_NT, 4);
    // run low: back to IDLE and stay
    add(0, 0, BEQ, 4'h0, 3'd0, O_NONE, 5);
    add(0, 0, BEQ, 4'h0, 3'd0, O_NONE, 5);
    // Illegal opcode: HALT is sticky while run toggles
    add(0, 1, ILL, 4'h0, 3'd1, O_FETCH, 5);
    add(0, 1, ILL, 4'h0, 3'd2, O_NONE,  5);
    add(0, 1, ILL, 4'h0, 3'd6, O_HALT,  5);
    for (int i = 0; i < 10; i++) add(0, logic'(i % 2), ILL, 4'h0, 3'd6, O_HALT, 5);
    add(1, 0, ILL, 4'h0, 3'd0, O_NONE, 0);
    add(0, 0, ILL, 4'h0, 3'd0, O_NONE, 0);
    // Reset during MEMORY of an LD
    add(0, 1, LD, 4'h0, 3'd1, O_FETCH, 0);
    add(0, 1, LD, 4'h0, 3'd2, O_NONE,  0);
    add(0, 1, LD, 4'h0, 3'd3, O_I_EX,  0);
    add(0, 1, LD, 4'h0, 3'd4, O_LD_MM, 0);
    add(1, 1, LD, 4'h0, 3'd0, O_NONE,  0);
    add(0, 0, LD, 4'h0, 3'd0, O_NONE,  0);
    // Five ADDIs; run drops while the fifth is in EXECUTE
    for (int k = 0; k < 5; k++) begin
      add(0, 1, ADDI, 4'h0, 3'd1, O_FETCH, k);
      add(0, 1, ADDI, 4'h0, 3'd2, O_NONE,  k);
      add(0, 1, ADDI, 4'h0, 3'd3, O_I_EX,  k);
      add(0, (k != 4), ADDI, 4'h0, 3'd5, O_AI_WB, k);
    end
    add(0, 0, ADDI, 4'h0, 3'd0, O_NONE, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      run = vecs[i].run;
      op  = vecs[i].op;
      fl  = vecs[i].fl;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), vecs[i].st, vecs[i].outs, vecs[i].cnt);
    end

    // Hand sequence: inputs change mid-cycle during EXECUTE of an R-type;
    // outputs must not move until the next edge, and the held opcode rules.
    rst = 1'b0; run = 1'b1; op = R; fl = 4'h0;
    @(posedge clk); #1;
    check_all("hs fetch", 3'd1, O_FETCH, 5);
    @(posedge clk); #1;
    check_all("hs decode", 3'd2, O_NONE, 5);
    @(posedge clk); #1;
    check_all("hs exec", 3'd3, O_NONE, 5);
    op = ILL; fl = 4'h4;
    #2;
    check_all("hs exec late", 3'd3, O_NONE, 5);
    @(posedge clk); #1;
    check_all("hs wb", 3'd5, O_R_WB, 5);
    run = 1'b0;
    @(posedge clk); #1;
    check_all("hs idle", 3'd0, O_NONE, 6);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
